// File: rtl/bean_bus_pkg.sv
// Shared types and constants for the unified memory bus: access-mode codes,
// arbiter FSM states, grant identifiers and the round-robin pick function.
package bean_bus_pkg;

  localparam logic [2:0] MODE_WORD   = 3'b000;
  localparam logic [2:0] MODE_HALF   = 3'b001;
  localparam logic [2:0] MODE_BYTE   = 3'b010;
  localparam int         MODE_SIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_t;

  // A lone requester always wins; on a tie the side that was not served last wins.
  function automatic grant_t rr_pick(input logic cpu_req, input logic dbg_req,
                                     input grant_t last_grant);
    grant_t pick;
    if (cpu_req && !dbg_req) begin
      pick = GNT_CPU;
    end else if (dbg_req && !cpu_req) begin
      pick = GNT_DBG;
    end else begin
      pick = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pick is combinational; the last_grant
// register only moves when the parent actually commits a grant.
module rr_arbiter2
  import bean_bus_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  logic   grant_en,
  output logic   any_req,
  output grant_t grant
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  // Compute the winner and the next last_grant value.
  always_comb begin
    any_req      = req_cpu | req_dbg;
    grant        = rr_pick(req_cpu, req_dbg, last_grant_q);
    last_grant_d = last_grant_q;
    if (grant_en && any_req) begin
      last_grant_d = grant;
    end
  end

  // last_grant starts at DBG so the first tie after reset goes to the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GNT_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between the CPU and the debug loader.
// One transaction in flight: IDLE latches the winner's request onto mem_*,
// BUSY waits for mem_ready or the timeout, DONE pulses the winner's ack.
module mem_bus_arbiter
  import bean_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_mode,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [2:0]        dbg_mode,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  grant_t            winner_q, winner_d;
  logic [7:0]        count_q, count_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_mode_q, mem_mode_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic   grant_en;
  logic   any_req;
  grant_t grant;

  rr_arbiter2 u_rr_arbiter2 (
    .clk      (clk),
    .reset    (reset),
    .req_cpu  (cpu_req),
    .req_dbg  (dbg_req),
    .grant_en (grant_en),
    .any_req  (any_req),
    .grant    (grant)
  );

  // Next-state logic for the transaction FSM, timeout counter and all outputs.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    count_d     = count_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    cpu_ack_d   = cpu_ack_q;
    dbg_ack_d   = dbg_ack_q;
    bus_err_d   = bus_err_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_en  = 1'b1;
          winner_d  = grant;
          mem_req_d = 1'b1;
          count_d   = 8'd0;
          state_d   = ST_BUSY;
          if (grant == GNT_CPU) begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_mode_d  = cpu_mode;
          end else begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            mem_mode_d  = dbg_mode;
          end
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b0;
          state_d   = ST_DONE;
          if (winner_q == GNT_CPU) begin
            cpu_ack_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = mem_rdata;
          end else begin
            dbg_ack_d = 1'b1;
            if (!mem_we_q) dbg_rdata_d = mem_rdata;
          end
        end else if (count_q == COUNT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
          if (winner_q == GNT_CPU) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            dbg_ack_d   = 1'b1;
            dbg_rdata_d = '0;
          end
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      ST_DONE: begin
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        bus_err_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        bus_err_d = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; reset aborts any transaction without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      winner_q    <= GNT_CPU;
      count_q     <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= 3'b000;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      bus_err_q   <= bus_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign bus_err   = bus_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mode  = mem_mode_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: handshake timing, round-robin,
// writes, timeout, asynchronous reset abort and input isolation during BUSY.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_mode;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [2:0]  dbg_mode;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_mode  (cpu_mode),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_mode  (dbg_mode),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mode  (mem_mode),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_mode = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_mode = '0;
    mem_rdata = '0; mem_ready = 0;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_we, cpu_ack, dbg_ack, bus_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, cpu_ack, dbg_ack, bus_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_mode} !== 67'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus: got %h %h %b expected all zero", mem_addr, mem_wdata, mem_mode);
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", cpu_rdata, dbg_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_no_req: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_cpu_read;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_mode = 3'b000;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("[TB] FAIL cpu_read_issue: got req=%b we=%b addr=%h expected 1 0 00000100", mem_req, mem_we, mem_addr);
    end
    tick();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_early_ack: got %b expected 0", cpu_ack);
    end
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, bus_err, mem_req} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL cpu_read_ack: got ack/dack/err/req=%b expected 1000", {cpu_ack, dbg_ack, bus_err, mem_req});
    end
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL cpu_read_data: got %h expected deadbeef", cpu_rdata);
    end
    cpu_req = 0; mem_ready = 0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_ack_pulse: got %b expected 0", cpu_ack);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    tick();
    checks++;
    if (mem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL rr_grant1_cpu: got addr %h expected 00000010", mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hC0C00001;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, cpu_rdata} !== {2'b10, 32'hC0C00001}) begin
      errors++;
      $display("[TB] FAIL rr_ack1: got acks=%b data=%h expected 10 c0c00001", {cpu_ack, dbg_ack}, cpu_rdata);
    end
    cpu_req = 0; mem_ready = 0;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, mem_req} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rr_idle_gap: got %b expected 000", {cpu_ack, dbg_ack, mem_req});
    end
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin
      errors++;
      $display("[TB] FAIL rr_grant2_dbg: got req=%b addr=%h expected 1 00000020", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hA5A50001;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, dbg_rdata} !== {2'b01, 32'hA5A50001}) begin
      errors++;
      $display("[TB] FAIL rr_ack2: got acks=%b data=%h expected 01 a5a50001", {cpu_ack, dbg_ack}, dbg_rdata);
    end
    cpu_req = 1; dbg_req = 1; mem_ready = 0;
    tick();
    tick();
    checks++;
    if (mem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL rr_grant3_cpu: got addr %h expected 00000010", mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hC0C00002;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rr_ack3: got %b expected 10", {cpu_ack, dbg_ack});
    end
    mem_ready = 0;
    tick();
    tick();
    checks++;
    if (mem_addr !== 32'h20) begin
      errors++;
      $display("[TB] FAIL rr_grant4_dbg: got addr %h expected 00000020", mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hA5A50002;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, dbg_rdata, cpu_rdata} !== {2'b01, 32'hA5A50002, 32'hC0C00002}) begin
      errors++;
      $display("[TB] FAIL rr_ack4: got acks=%b dbg=%h cpu=%h expected 01 a5a50002 c0c00002", {cpu_ack, dbg_ack}, dbg_rdata, cpu_rdata);
    end
    cpu_req = 0; dbg_req = 0; mem_ready = 0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_drained: got mem_req %b expected 0", mem_req);
    end
  endtask

  task automatic test_dbg_write;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200; dbg_wdata = 32'h12345678; dbg_mode = 3'b010;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_mode} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 3'b010}) begin
      errors++;
      $display("[TB] FAIL dbg_write_issue: got req=%b we=%b addr=%h data=%h mode=%b", mem_req, mem_we, mem_addr, mem_wdata, mem_mode);
    end
    mem_ready = 1; mem_rdata = 32'hFFFF0000;
    tick();
    checks++;
    if ({dbg_ack, cpu_ack, bus_err, mem_req} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL dbg_write_ack: got dack/ack/err/req=%b expected 1000", {dbg_ack, cpu_ack, bus_err, mem_req});
    end
    checks++;
    if (dbg_rdata !== 32'hA5A50002) begin
      errors++;
      $display("[TB] FAIL dbg_write_rdata_held: got %h expected a5a50002", dbg_rdata);
    end
    dbg_req = 0; dbg_we = 0; dbg_mode = 3'b000; mem_ready = 0;
    tick();
    checks++;
    if (dbg_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dbg_write_ack_pulse: got %b expected 0", dbg_ack);
    end
  endtask

  task automatic test_timeout;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h400; mem_ready = 0;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if ({cpu_ack, mem_req} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL timeout_busy_%0d: got ack/req=%b expected 01", i, {cpu_ack, mem_req});
      end
    end
    tick();
    checks++;
    if ({cpu_ack, bus_err, mem_req, cpu_rdata} !== {3'b110, 32'h0}) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got ack/err/req=%b data=%h expected 110 00000000", {cpu_ack, bus_err, mem_req}, cpu_rdata);
    end
    cpu_req = 0;
    tick();
    checks++;
    if ({cpu_ack, bus_err} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got ack/err=%b expected 00", {cpu_ack, bus_err});
    end
  endtask

  task automatic test_reset_mid_busy;
    cpu_req = 1; cpu_addr = 32'h500;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, cpu_ack, dbg_ack, bus_err, mem_addr, dbg_rdata} !== {4'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_abort: got ctrl=%b addr=%h dbg_rdata=%h expected 0000 0 0", {mem_req, cpu_ack, dbg_ack, bus_err}, mem_addr, dbg_rdata);
    end
    cpu_req = 0; mem_ready = 1;
    tick();
    reset = 1'b0; mem_ready = 0;
    tick();
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, mem_req} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_no_ack: got %b expected 000", {cpu_ack, dbg_ack, mem_req});
    end
  endtask

  task automatic test_ignore_changes;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300; cpu_wdata = 32'h0;
    tick();
    cpu_addr = 32'h999; cpu_we = 1; cpu_wdata = 32'hBAD;
    tick();
    checks++;
    if ({mem_addr, mem_we, mem_wdata} !== {32'h300, 1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL ignore_busy_inputs: got addr=%h we=%b data=%h expected 00000300 0 00000000", mem_addr, mem_we, mem_wdata);
    end
    mem_ready = 1; mem_rdata = 32'h600DF00D;
    tick();
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 32'h600DF00D}) begin
      errors++;
      $display("[TB] FAIL ignore_ack: got ack=%b data=%h expected 1 600df00d", cpu_ack, cpu_rdata);
    end
    cpu_req = 0; cpu_we = 0; mem_ready = 0;
    tick();
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    checks++;
    if ({cpu_ack, dbg_ack, mem_req} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL stray_ready_no_ack: got %b expected 000", {cpu_ack, dbg_ack, mem_req});
    end
    tick();
    checks++;
    if ({mem_addr, cpu_rdata, cpu_ack} !== {32'h300, 32'h600DF00D, 1'b0}) begin
      errors++;
      $display("[TB] FAIL stray_ready_hold: got addr=%h data=%h ack=%b expected 00000300 600df00d 0", mem_addr, cpu_rdata, cpu_ack);
    end
    mem_ready = 0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] starting mem_bus_arbiter tests");
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_dbg_write();
    test_timeout();
    test_reset_mid_busy();
    test_ignore_changes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
